// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle RISC control FSM.
package cpu_pkg;

  localparam int unsigned STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    StRst,
    StIf1,
    StIf2,
    StUpc,
    StDec,
    StWimm,
    StGeta,
    StGetb,
    StComp,
    StWrd,
    StAddr,
    StLadr,
    StMrd,
    StMwb,
    StGetd,
    StSpass,
    StMwr,
    StHalt
  } state_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;
  localparam logic [2:0] OpcLdr = 3'b011;
  localparam logic [2:0] OpcStr = 3'b100;
  localparam logic [2:0] OpcHlt = 3'b111;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluCmp = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluMvn = 2'b11;

  localparam logic [1:0] MemNone  = 2'b00;
  localparam logic [1:0] MemRead  = 2'b01;
  localparam logic [1:0] MemWrite = 2'b10;

  localparam logic [1:0] VselC     = 2'b00;
  localparam logic [1:0] VselPc    = 2'b01;
  localparam logic [1:0] VselImm   = 2'b10;
  localparam logic [1:0] VselMdata = 2'b11;

  localparam logic [2:0] NselNone = 3'b000;
  localparam logic [2:0] NselRn   = 3'b001;
  localparam logic [2:0] NselRd   = 3'b010;
  localparam logic [2:0] NselRm   = 3'b100;

endpackage

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: fetch, PC update, decode, execute, write-back.
// Optional instruction counter enabled by CPU_CONTROLLER_INSN_COUNT_EN.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned STATE_W = cpu_pkg::STATE_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
`ifdef CPU_CONTROLLER_INSN_COUNT_EN
  ,
  output logic [15:0] insn_count
`endif
);

  logic [STATE_W-1:0] state_q;
  state_e             state_cur;
  state_e             state_d;

  assign state_cur = state_e'(state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_cur;
    unique case (state_cur)
      StRst:  state_d = StIf1;
      StIf1:  state_d = StIf2;
      StIf2:  state_d = StUpc;
      StUpc:  state_d = StDec;
      StDec: begin
        if (opcode == OpcMov && op == 2'b10) begin
          state_d = StWimm;
        end else if (opcode == OpcMov && op == 2'b00) begin
          state_d = StGetb;
        end else if (opcode == OpcAlu) begin
          state_d = StGeta;
        end else if ((opcode == OpcLdr || opcode == OpcStr) && op == 2'b00) begin
          state_d = StGeta;
        end else if (opcode == OpcHlt) begin
          state_d = StHalt;
        end else begin
          state_d = StHalt;
        end
      end
      StWimm: state_d = StIf1;
      StGeta: state_d = (opcode == OpcAlu) ? StGetb : StAddr;
      StGetb: state_d = StComp;
      StComp: state_d = (opcode == OpcAlu && op == AluCmp) ? StIf1 : StWrd;
      StWrd:  state_d = StIf1;
      StAddr: state_d = StLadr;
      StLadr: state_d = (opcode == OpcLdr) ? StMrd : StGetd;
      StMrd:  state_d = StMwb;
      StMwb:  state_d = StIf1;
      StGetd: state_d = StSpass;
      StSpass: state_d = StMwr;
      StMwr:  state_d = StIf1;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    nsel      = NselNone;
    vsel      = VselC;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    write     = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MemNone;
    halted    = 1'b0;
    unique case (state_cur)
      StRst: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      StIf1: begin
        addr_sel = 1'b1;
        mem_cmd  = MemRead;
      end
      StIf2: begin
        addr_sel = 1'b1;
        mem_cmd  = MemRead;
        load_ir  = 1'b1;
      end
      StUpc: load_pc = 1'b1;
      StDec: ;
      StWimm: begin
        nsel  = NselRn;
        vsel  = VselImm;
        write = 1'b1;
      end
      StGeta: begin
        nsel  = NselRn;
        loada = 1'b1;
      end
      StGetb: begin
        nsel  = NselRm;
        loadb = 1'b1;
      end
      StComp: begin
        // CMP only updates status; MOV reg passes B through a zeroed A.
        if (opcode == OpcAlu && op == AluCmp) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
        asel = (opcode == OpcMov);
      end
      StWrd: begin
        nsel  = NselRd;
        vsel  = VselC;
        write = 1'b1;
      end
      StAddr: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      StLadr: load_addr = 1'b1;
      StMrd:  mem_cmd = MemRead;
      StMwb: begin
        mem_cmd = MemRead;
        nsel    = NselRd;
        vsel    = VselMdata;
        write   = 1'b1;
      end
      StGetd: begin
        nsel  = NselRd;
        loadb = 1'b1;
      end
      StSpass: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      StMwr:  mem_cmd = MemWrite;
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef CPU_CONTROLLER_INSN_COUNT_EN
  logic [15:0] insn_count_q;
  logic [15:0] insn_count_d;

  always_comb begin
    insn_count_d = insn_count_q;
    if (state_cur == StDec && state_d != StHalt) begin
      insn_count_d = insn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      insn_count_q <= 16'd0;
    end else begin
      insn_count_q <= insn_count_d;
    end
  end

  assign insn_count = insn_count_q;
`else
  // Counter absent in this build.
`endif

endmodule
